// File: rtl/iir_frame_ctrl.sv
// iir_frame_ctrl: streams one frame from input RAM through the biquad cascade into output RAM,
// clearing cascade state first and bounding the drain with an idle watchdog.
module iir_frame_ctrl #(
    parameter int FRAME_LEN  = 2048,
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 24,
    parameter int CLR_CYCLES = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     ram_rd_en,
    output logic [ADDR_W-1:0]        ram_rd_addr,
    input  logic signed [DATA_W-1:0] ram_rd_data,
    output logic                     filt_clr,
    output logic                     filt_en,
    output logic signed [DATA_W-1:0] filt_in_data,
    output logic                     filt_in_valid,
    input  logic signed [DATA_W-1:0] filt_out_data,
    input  logic                     filt_out_valid,
    output logic                     ram_wr_en,
    output logic [ADDR_W-1:0]        ram_wr_addr,
    output logic signed [DATA_W-1:0] ram_wr_data,
    output logic                     busy,
    output logic                     filter_done,
    output logic                     timeout_err
);
    localparam int CW = $clog2(CLR_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0]   FLEN     = (ADDR_W + 1)'(FRAME_LEN);
    localparam logic [ADDR_W:0]   FLEN_M1  = (ADDR_W + 1)'(FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] RD_LAST  = ADDR_W'(FRAME_LEN - 1);
    localparam logic [CW-1:0]     CLR_LAST = CW'(CLR_CYCLES - 1);
    localparam logic [WW-1:0]     WD_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t          state;
    logic [ADDR_W:0] out_cnt;
    logic [CW-1:0]   clr_cnt;
    logic [WW-1:0]   wd_cnt;
    logic            cap;
    logic            last_out;

    // RAM read data arrives registered, so it is forwarded while its valid is up
    assign filt_in_data = filt_in_valid ? ram_rd_data : '0;
    assign cap          = filt_out_valid && (state == FEED || state == DRAIN) && out_cnt < FLEN;
    assign last_out     = cap && out_cnt == FLEN_M1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ram_rd_en     <= 1'b0;
            ram_rd_addr   <= '0;
            filt_clr      <= 1'b0;
            filt_en       <= 1'b0;
            filt_in_valid <= 1'b0;
            ram_wr_en     <= 1'b0;
            ram_wr_addr   <= '0;
            ram_wr_data   <= '0;
            busy          <= 1'b0;
            filter_done   <= 1'b0;
            timeout_err   <= 1'b0;
            out_cnt       <= '0;
            clr_cnt       <= '0;
            wd_cnt        <= '0;
        end else begin
            filt_in_valid <= ram_rd_en;
            ram_wr_en     <= cap;
            filter_done   <= 1'b0;
            if (cap) begin
                ram_wr_addr <= out_cnt[ADDR_W-1:0];
                ram_wr_data <= filt_out_data;
                out_cnt     <= out_cnt + 1'b1;
            end
            case (state)
                IDLE: if (start) begin
                    state       <= CLEAR;
                    busy        <= 1'b1;
                    filt_clr    <= 1'b1;
                    timeout_err <= 1'b0;
                    clr_cnt     <= '0;
                    out_cnt     <= '0;
                end
                CLEAR: if (clr_cnt == CLR_LAST) begin
                    state       <= FEED;
                    filt_clr    <= 1'b0;
                    filt_en     <= 1'b1;
                    ram_rd_en   <= 1'b1;
                    ram_rd_addr <= '0;
                end else begin
                    clr_cnt <= clr_cnt + 1'b1;
                end
                FEED: if (ram_rd_addr == RD_LAST) begin
                    state     <= DRAIN;
                    ram_rd_en <= 1'b0;
                    wd_cnt    <= '0;
                end else begin
                    ram_rd_addr <= ram_rd_addr + 1'b1;
                end
                DRAIN: if (filt_out_valid) begin
                    wd_cnt <= '0;
                end else if (wd_cnt == WD_LAST) begin
                    state       <= DONE;
                    timeout_err <= 1'b1;
                    filter_done <= 1'b1;
                    filt_en     <= 1'b0;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            // a final output wins over a simultaneous watchdog expiry
            if (last_out) begin
                state       <= DONE;
                filter_done <= 1'b1;
                filt_en     <= 1'b0;
                ram_rd_en   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_iir_frame_ctrl.sv
// tb_iir_frame_ctrl: random frames through a delay-line cascade model, checked against expected RAM traffic
module tb_iir_frame_ctrl;
    localparam int FL = 2048;
    localparam int TO = 64;
    localparam int CC = 8;
    localparam int LMAX = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ram_rd_en, filt_clr, filt_en, filt_in_valid, filt_out_valid, ram_wr_en, busy, filter_done, timeout_err;
    logic [10:0] ram_rd_addr, ram_wr_addr;
    logic [23:0] ram_rd_data, filt_in_data, filt_out_data, ram_wr_data;

    logic st1 = 1'b0;
    logic rd1, clr1, en1, fiv1, we1, busy1, done1, to1;
    logic fov1 = 1'b0;
    logic [10:0] ra1, wa1;
    logic [23:0] rdd1 = '0;
    logic [23:0] fod1 = '0;
    logic [23:0] fid1, wd1;

    logic [23:0] mem [FL];
    logic [23:0] pd [LMAX];
    logic        pv [LMAX];
    int lat = 12;
    int mode = 0;
    int in_cnt = 0;
    int extra = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    iir_frame_ctrl u0 (
        .clk(clk), .rst(rst), .start(start),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .filt_clr(filt_clr), .filt_en(filt_en), .filt_in_data(filt_in_data), .filt_in_valid(filt_in_valid),
        .filt_out_data(filt_out_data), .filt_out_valid(filt_out_valid),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .busy(busy), .filter_done(filter_done), .timeout_err(timeout_err)
    );

    iir_frame_ctrl #(.FRAME_LEN(1), .CLR_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .start(st1),
        .ram_rd_en(rd1), .ram_rd_addr(ra1), .ram_rd_data(rdd1),
        .filt_clr(clr1), .filt_en(en1), .filt_in_data(fid1), .filt_in_valid(fiv1),
        .filt_out_data(fod1), .filt_out_valid(fov1),
        .ram_wr_en(we1), .ram_wr_addr(wa1), .ram_wr_data(wd1),
        .busy(busy1), .filter_done(done1), .timeout_err(to1)
    );

    // one-cycle RAM plus a pure delay-line cascade; mode 1 drops the last sample, mode 2 adds 3 trailing outputs
    always @(posedge clk) begin
        ram_rd_data <= mem[ram_rd_addr];
        rdd1 <= 24'h00A5C3 ^ {13'd0, ra1};
        fov1 <= fiv1;
        fod1 <= fid1;
        if (filt_clr) begin
            for (int i = 0; i < LMAX; i++) pv[i] <= 1'b0;
            in_cnt <= 0;
            extra <= 0;
        end else begin
            pv[0] <= (filt_in_valid && !(mode == 1 && in_cnt == FL - 1)) || extra > 0;
            pd[0] <= filt_in_valid ? filt_in_data : 24'($urandom);
            for (int i = 1; i < LMAX; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
            if (filt_in_valid) begin
                in_cnt <= in_cnt + 1;
                if (mode == 2 && in_cnt == FL - 1) extra <= 3;
            end else if (extra > 0) begin
                extra <= extra - 1;
            end
        end
    end
    assign filt_out_valid = pv[lat-1];
    assign filt_out_data  = pd[lat-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // m: cascade mode; hold: keep start high; rst_at: abort after that many reads (0 = never)
    task automatic run_frame(input int m, input bit hold, input int rst_at);
        int rd_n = 0, in_n = 0, wr_n = 0, clr_n = 0, last_fov = -1000, done_c = -1;
        for (int i = 0; i < FL; i++) mem[i] = 24'($urandom);
        mode = m;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (c == 0) begin
                chk("clear_entry", {busy, filt_clr, filt_en, timeout_err}, 4'b1100);
            end
            if (filt_clr) begin
                clr_n++;
                chk("clr_en_low", filt_en, 0);
            end
            if (ram_rd_en) begin
                chk("rd_addr", ram_rd_addr, rd_n);
                chk("feed_en", filt_en, 1);
                rd_n++;
            end
            if (filt_in_valid) begin
                chk("fin_data", filt_in_data, in_n < FL ? mem[in_n] : 24'h0);
                in_n++;
            end
            if (ram_wr_en) begin
                chk("wr_in_range", wr_n < FL, 1);
                if (wr_n < FL) begin
                    chk("wr_addr", ram_wr_addr, wr_n);
                    chk("wr_data", ram_wr_data, mem[wr_n]);
                end
                wr_n++;
            end
            if (filt_out_valid) last_fov = c;
            if (rst_at > 0 && rd_n == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_state", {busy, ram_rd_en, ram_wr_en, filt_clr, filt_en, filt_in_valid, filter_done, timeout_err}, 8'h00);
                return;
            end
            if (filter_done) begin
                done_c = c;
                break;
            end
        end
        chk("done_seen", done_c >= 0, 1);
        chk("clr_cycles", clr_n, CC);
        chk("reads", rd_n, FL);
        chk("fin_valids", in_n, FL);
        chk("writes", wr_n, m == 1 ? FL - 1 : FL);
        chk("timeout_err", timeout_err, m == 1);
        if (m == 1) chk("timeout_delay", done_c - last_fov, TO + 1);
        @(negedge clk);
        chk("idle_after_done", {busy, filter_done, ram_wr_en}, 3'b000);
        chk("err_sticky", timeout_err, m == 1);
        if (hold) begin
            @(negedge clk);
            chk("restart_clear", {busy, filt_clr}, 2'b11);
            start = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < FL; i++) mem[i] = 24'(i);
        for (int i = 0; i < LMAX; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        start = 1'b1;
        st1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_start_idle", {busy, busy1, filt_clr, clr1}, 4'b0000);
        chk("rst_outputs", {ram_rd_en, ram_wr_en, filt_en, filt_in_valid, filter_done, timeout_err}, 6'b0);
        start = 1'b0;
        st1 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        begin
            int r = 0, w = 0, d = 0, cl = 0;
            st1 = 1'b1;
            @(negedge clk);
            st1 = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (clr1) cl++;
                if (rd1) begin
                    chk("fl1_rd_addr", ra1, 0);
                    r++;
                end
                if (we1) begin
                    chk("fl1_wr_addr", wa1, 0);
                    chk("fl1_wr_data", wd1, 24'h00A5C3);
                    w++;
                end
                if (done1) d++;
                @(negedge clk);
            end
            chk("fl1_clr", cl, 1);
            chk("fl1_reads", r, 1);
            chk("fl1_writes", w, 1);
            chk("fl1_done", d, 1);
            chk("fl1_state", {busy1, to1}, 2'b00);
        end

        lat = 12;
        run_frame(0, 1'b0, 0);
        lat = $urandom_range(1, LMAX);
        run_frame(1, 1'b0, 0);
        lat = $urandom_range(1, LMAX);
        run_frame(0, 1'b0, 500);
        lat = $urandom_range(1, LMAX);
        run_frame(0, 1'b0, 0);
        lat = $urandom_range(1, LMAX);
        run_frame(2, 1'b0, 0);
        lat = $urandom_range(1, LMAX);
        run_frame(0, 1'b1, 0);
        lat = $urandom_range(1, LMAX);
        run_frame(1, 1'b0, 0);
        lat = $urandom_range(1, LMAX);
        run_frame(int'($urandom_range(0, 2)), 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
